pulse_train_generator: RTL



---
 rtl/pulse_gen_pkg.sv | 21 ++
 rtl/pulse_gen_lfsr.sv | 29 ++
 rtl/pulse_train_generator.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding and
// the LFSR seed/taps used by the optional PRBS gap mode (PULSE_GEN_PRBS_EN).
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci shift. A non-zero state can never map to zero: an all-zero
  // result needs v[14:0]=0, i.e. v=16'h8000, whose feedback bit is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per advance strobe. Only used when
// PULSE_GEN_PRBS_EN is defined, to randomise the gap between test pulses.
module pulse_gen_lfsr
  import pulse_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Next LFSR state: shift only when asked to.
  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr_step(value_q);
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= LFSR_SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable test pulse source: bursts of fixed-width pulses separated by
// programmable gaps, with busy/done/sent_count progress reporting.
// Optional feature macro: PULSE_GEN_PRBS_EN (adds prbs_mode and an LFSR that
// masks the gap value to give randomised pulse spacing).
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH_W = 8,
  parameter int GAP_W   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] pulse_width,
  input  logic [GAP_W-1:0]   gap,
  input  logic [COUNT_W-1:0] burst_len,
`ifdef PULSE_GEN_PRBS_EN
  input  logic               prbs_mode,
`endif
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent_count
);

  localparam int CNT_W = (WIDTH_W > GAP_W) ? WIDTH_W : GAP_W;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [COUNT_W-1:0] sent_inc;
  logic [GAP_W-1:0]   gap_eff;

  // Counters are loaded with length-1; a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] width_load(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? '0 : CNT_W'(w - WIDTH_W'(1));
  endfunction

  function automatic logic [CNT_W-1:0] gap_load(input logic [GAP_W-1:0] g);
    return (g == '0) ? '0 : CNT_W'(g - GAP_W'(1));
  endfunction

  assign sent_inc = sent_q + COUNT_W'(1);

`ifdef PULSE_GEN_PRBS_EN
  logic        prbs_q, prbs_d;
  logic        lfsr_adv;
  logic [15:0] lfsr_value;

  pulse_gen_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // In PRBS mode the gap field masks the current LFSR value.
  assign gap_eff = prbs_q ? (lfsr_value[GAP_W-1:0] & gap_q) : gap_q;
`else
  assign gap_eff = gap_q;
`endif

  // Next-state, counter and output logic of the burst FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    gap_d   = gap_q;
    len_d   = len_q;
    sent_d  = sent_q;
    done_d  = 1'b0;
`ifdef PULSE_GEN_PRBS_EN
    prbs_d   = prbs_q;
    lfsr_adv = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = HIGH;
          width_d = pulse_width;
          gap_d   = gap;
          len_d   = burst_len;
          sent_d  = '0;
          cnt_d   = width_load(pulse_width);
`ifdef PULSE_GEN_PRBS_EN
          prbs_d  = prbs_mode;
`endif
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          sent_d = sent_inc;
          if (len_q == '0 || sent_inc != len_q) begin
            state_d = LOW;
            cnt_d   = gap_load(gap_eff);
`ifdef PULSE_GEN_PRBS_EN
            lfsr_adv = 1'b1;
`endif
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = width_load(width_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset returns everything to idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PULSE_GEN_PRBS_EN
      prbs_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PULSE_GEN_PRBS_EN
      prbs_q  <= prbs_d;
`endif
    end
  end

  assign pulse_out  = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;

endmodule
